// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: receive end of a 4:1 TDM link, splitting valid words onto four registered channels.
// Define DEMUX_SYNC_ERR_EN to enable the sticky sync-misalignment err flag (otherwise err is tied to 0).
module demux1to4_tdm #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in,
  input  logic          in_vld,
  input  logic          sync,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic          frm_vld,
  output logic [1:0]    sel,
  output logic          err
);
  logic [DW-1:0] sh0, sh1, sh2;
  logic start, mid1, mid2, last;
  // sync restarts the frame at channel 0 and overrides whatever channel sel points at
  assign start = in_vld && (sync || sel == 2'd0);
  assign mid1  = in_vld && !sync && sel == 2'd1;
  assign mid2  = in_vld && !sync && sel == 2'd2;
  assign last  = in_vld && !sync && sel == 2'd3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel     <= 2'd0;
      sh0     <= '0;
      sh1     <= '0;
      sh2     <= '0;
      out0    <= '0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      frm_vld <= 1'b0;
    end else begin
      frm_vld <= last;
      if (in_vld) sel <= start ? 2'd1 : sel + 2'd1;
      if (start) sh0 <= in;
      if (mid1) sh1 <= in;
      if (mid2) sh2 <= in;
      if (last) begin
        out0 <= sh0;
        out1 <= sh1;
        out2 <= sh2;
        out3 <= in;
      end
    end
  end
`ifdef DEMUX_SYNC_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (in_vld && sync && sel != 2'd0) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/demux1to4_tdm.md
DEMUX1TO4_TDM -- requirements
Module: demux1to4_tdm

Interface
REQ-001 Parameter DW, default 1, width in bits of the input stream and of each channel output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in  input  DW  time-division-multiplexed input word.
REQ-005 in_vld  input  1  in carries a valid word this cycle.
REQ-006 sync  input  1  frame marker; qualified by in_vld, marks the current word as channel 0.
REQ-007 out0  output  DW  registered channel 0 word of last completed frame.
REQ-008 out1  output  DW  registered channel 1 word of last completed frame.
REQ-009 out2  output  DW  registered channel 2 word of last completed frame.
REQ-010 out3  output  DW  registered channel 3 word of last completed frame.
REQ-011 frm_vld  output  1  one-cycle pulse: out0..out3 updated with a new complete frame.
REQ-012 sel  output  2  registered channel index the next valid word will be written to.
REQ-013 err  output  1  sticky sync-misalignment flag (see Configuration).

Function
REQ-014 The block SHALL be the receive end of a 4:1 mux link: consecutive valid words go to channels 0,1,2,3 in order, selected by sel.
REQ-015 On an edge with in_vld=1 and sync=0, the block SHALL store in into shadow register sel and increment sel modulo 4 (3 wraps to 0).
REQ-016 On an edge with in_vld=1 and sync=1, the block SHALL store in into shadow 0 and set sel to 1, regardless of prior sel.
REQ-017 Sync with sel!=0 SHALL discard the partial frame; no frm_vld for it, out0..out3 unchanged.
REQ-018 With in_vld=0, sel, shadows and outputs SHALL hold; sync SHALL be ignored.
REQ-019 On the edge storing channel 3, out0..out2 SHALL load shadows 0..2 and out3 SHALL load in, all on that same edge.
REQ-020 frm_vld SHALL be 1 for exactly the cycle after that edge (latency 1 clock from channel-3 word), else 0.
REQ-021 out0..out3 SHALL stay stable between frm_vld pulses; partial frames never visible on outputs.
REQ-022 Back-to-back frames with in_vld continuously 1 SHALL produce frm_vld every 4th cycle, no bubble.
REQ-023 Sync is optional after the first frame; with no sync, wrap-around alignment SHALL continue indefinitely.

Reset
REQ-024 With rst_n=0 at an edge: sel=0, all shadows=0, out0..out3=0, frm_vld=0, err=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; first valid word after reset goes to channel 0.
REQ-026 Reset SHALL take priority over in_vld and sync in the same cycle.

Configuration
REQ-027 Macro DEMUX_SYNC_ERR_EN defined: err SHALL set on any edge with in_vld=1, sync=1, sel!=0 and remain 1 until reset.
REQ-028 Macro not defined: err port SHALL remain present, tied to 0, no detection logic; all other behaviour identical.

Verification
REQ-029 DW=4, reset, then in_vld=1 words 0xA(sync),0xB,0xC,0xD -> next cycle out0..3=A,B,C,D, frm_vld=1 one cycle, sel=0.
REQ-030 Same frame with in_vld=0 gaps of 2 cycles between words -> identical outputs, single frm_vld pulse, sel holds during gaps.
REQ-031 Words 1(sync),2, then 5(sync),6,7,8 -> one frm_vld, outputs 5,6,7,8; err=1 with DEMUX_SYNC_ERR_EN, 0 without.
REQ-032 8 continuous words 1..8, sync only on first -> frm_vld at cycles 4 and 8 after start, final outputs 5,6,7,8.
REQ-033 After a full frame 1,2,3,4, send 9(sync),10, assert rst_n=0 one cycle -> all outputs 0, err=0, sel=0; next word 3 lands in channel 0.
REQ-034 sync=1 with in_vld=0 mid-frame -> no effect; frame completes normally with frm_vld.
